qos_stream_arbiter: RTL



---
 rtl/qos_arb_pkg.sv | 12 +
 rtl/qos_max_filter.sv | 27 ++
 rtl/qos_stream_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/qos_arb_pkg.sv
// Shared types and constants for the QoS stream arbiter.
package qos_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int unsigned STATS_CNT_WIDTH   = 16;
    localparam int unsigned QOS_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/qos_max_filter.sv
// Marks the valid streams whose QoS equals the maximum QoS among valid streams.
module qos_max_filter
#(
    parameter int unsigned STREAM_COUNT = 2,
    parameter int unsigned T_QOS_WIDTH  = 4
)(
    input  logic [STREAM_COUNT-1:0]                  valid_i,
    input  logic [STREAM_COUNT-1:0][T_QOS_WIDTH-1:0] qos_i,
    output logic [STREAM_COUNT-1:0]                  cand_o
);

    logic [T_QOS_WIDTH-1:0] max_qos;

    always_comb begin
        max_qos = '0;
        cand_o  = '0;
        for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
            if (valid_i[i] && (qos_i[i] > max_qos)) begin
                max_qos = qos_i[i];
            end
        end
        for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
            cand_o[i] = valid_i[i] && (qos_i[i] == max_qos);
        end
    end

endmodule

// File: rtl/qos_stream_arbiter.sv
// Packet-locked arbiter: highest QoS wins, ties rotate round-robin.
// Optional per-stream completed-packet counters under QOS_ARB_STATS_EN.
module qos_stream_arbiter
    import qos_arb_pkg::*;
#(
    parameter int unsigned STREAM_COUNT = 2,
    parameter int unsigned T_DATA_WIDTH = 8,
    parameter int unsigned T_QOS_WIDTH  = QOS_WIDTH_DEFAULT,
    parameter int unsigned T_ID___WIDTH = $clog2(STREAM_COUNT)
)(
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
    input  logic [STREAM_COUNT-1:0][T_QOS_WIDTH-1:0] s_qos_i,
    input  logic [STREAM_COUNT-1:0]                  s_last_i,
    input  logic [STREAM_COUNT-1:0]                  s_valid_i,
    output logic [STREAM_COUNT-1:0]                  s_ready_o,
    output logic [T_DATA_WIDTH-1:0]                  m_data_o,
    output logic [T_QOS_WIDTH-1:0]                   m_qos_o,
    output logic [T_ID___WIDTH-1:0]                  m_id_o,
    output logic                                     m_last_o,
    output logic                                     m_valid_o,
    input  logic                                     m_ready_i
`ifdef QOS_ARB_STATS_EN
    ,
    output logic [STREAM_COUNT-1:0][STATS_CNT_WIDTH-1:0] pkt_cnt_o
`endif
);

    localparam logic [STREAM_COUNT-1:0] PTR_RST = STREAM_COUNT'(1) << (STREAM_COUNT - 1);

    state_t                    state_q, state_d;
    logic [STREAM_COUNT-1:0]   grant_q, grant_d;
    logic [STREAM_COUNT-1:0]   ptr_q, ptr_d;
    logic [T_ID___WIDTH-1:0]   id_q, id_d;
    logic [T_QOS_WIDTH-1:0]    qos_q, qos_d;

    logic [STREAM_COUNT-1:0]   cand;
    logic [STREAM_COUNT-1:0]   win_oh;
    int unsigned               ptr_idx;
    int unsigned               win_idx;
    int unsigned               scan_idx;
    logic                      win_found;
    logic                      pkt_done;

    qos_max_filter #(
        .STREAM_COUNT (STREAM_COUNT),
        .T_QOS_WIDTH  (T_QOS_WIDTH)
    ) u_max_filter (
        .valid_i (s_valid_i),
        .qos_i   (s_qos_i),
        .cand_o  (cand)
    );

    // First candidate strictly after the pointer, wrapping around.
    always_comb begin
        ptr_idx   = 0;
        win_idx   = 0;
        scan_idx  = 0;
        win_found = 1'b0;
        win_oh    = '0;
        for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
            if (ptr_q[i]) begin
                ptr_idx = i;
            end
        end
        for (int unsigned off = 1; off <= STREAM_COUNT; off++) begin
            scan_idx = ptr_idx + off;
            if (scan_idx >= STREAM_COUNT) begin
                scan_idx = scan_idx - STREAM_COUNT;
            end
            if (!win_found && cand[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
        win_oh[win_idx] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        qos_d     = qos_q;
        s_ready_o = '0;
        m_valid_o = 1'b0;
        m_data_o  = '0;
        m_last_o  = 1'b0;
        pkt_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = win_oh;
                    ptr_d   = win_oh;
                    id_d    = T_ID___WIDTH'(win_idx);
                    qos_d   = s_qos_i[win_idx];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_ready_o = grant_q & {STREAM_COUNT{m_ready_i}};
                m_valid_o = s_valid_i[id_q];
                if (m_valid_o) begin
                    m_data_o = s_data_i[id_q];
                    m_last_o = s_last_i[id_q];
                end
                pkt_done = m_valid_o && m_ready_i && m_last_o;
                if (pkt_done) begin
                    state_d = IDLE;
                    grant_d = '0;
                    id_d    = '0;
                    qos_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_RST;
            id_q    <= '0;
            qos_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            qos_q   <= qos_d;
        end
    end

    assign m_id_o  = id_q;
    assign m_qos_o = qos_q;

`ifdef QOS_ARB_STATS_EN
    logic [STREAM_COUNT-1:0][STATS_CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Saturating count of completed packets per source.
    always_comb begin
        cnt_d = cnt_q;
        if (pkt_done && (cnt_q[id_q] != '1)) begin
            cnt_d[id_q] = cnt_q[id_q] + STATS_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pkt_cnt_o = cnt_q;
`endif

endmodule
